// File: rtl/pkt_mem_arbiter_if.sv
// Signal bundle between packet-buffer requesters, the arbiter and the memory.
// slave  : arbiter view (consumes requests, drives grants and the memory port)
// master : requester/memory view (drives requests and memory read data)
interface pkt_mem_arbiter_if #(
  parameter int NREQ   = 2,
  parameter int DWIDTH = 64,
  parameter int AWIDTH = 8
);
  // requester side
  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        we;
  logic [NREQ*AWIDTH-1:0] addr;
  logic [NREQ*DWIDTH-1:0] wdata;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        rvalid;
  logic [DWIDTH-1:0]      rdata;

  // memory side
  logic                   mem_en;
  logic                   mem_we;
  logic [AWIDTH-1:0]      mem_addr;
  logic [DWIDTH-1:0]      mem_wdata;
  logic [DWIDTH-1:0]      mem_rdata;

  modport slave (
    input  req, we, addr, wdata, mem_rdata,
    output gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req, we, addr, wdata, mem_rdata,
    input  gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/pkt_mem_arbiter.sv
// Single-port packet-buffer arbiter: one access per cycle, round-robin with a
// bounded burst lock, registered per-requester read-valid strobes.
module pkt_mem_arbiter #(
  parameter int NREQ      = 2,
  parameter int DWIDTH    = 64,
  parameter int AWIDTH    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,   // async, active low
  pkt_mem_arbiter_if.slave  bus
);
  localparam int            OW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int            BW       = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0] BSAT     = BW'(MAX_BURST - 1);
  localparam logic [OW-1:0] OWN_RST  = OW'(NREQ - 1);
  localparam int            WAIT_MAX = (NREQ - 1) * MAX_BURST + 1;
  localparam int            WW       = $clog2(WAIT_MAX + 1) + 1;

  logic [OW-1:0]   owner_q, owner_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  // Set from reset until the first grant. The reset owner has not really been
  // granted anything, so it gets no burst credit: any other requester beats it,
  // which is what gives requester 0 first priority after reset.
  logic            fresh_q, fresh_d;
  logic [NREQ-1:0] rvalid_q, rvalid_d;

  logic [NREQ-1:0] others;
  logic            keep;
  logic            hit;
  logic            grant;
  logic [OW-1:0]   gsel;
  logic [OW-1:0]   idx;

  // choose this cycle's winner: keep the owner inside its burst, else rotate
  always_comb begin
    others          = bus.req;
    others[owner_q] = 1'b0;
    keep            = bus.req[owner_q] &&
                      ((!fresh_q && (bcnt_q < BSAT)) || (others == '0));
    hit             = 1'b0;
    gsel            = owner_q;
    idx             = owner_q;
    if (keep) begin
      hit = 1'b1;
    end else begin
      for (int k = 1; k < NREQ; k++) begin
        idx = OW'((int'(owner_q) + k) % NREQ);
        if (!hit && bus.req[idx]) begin
          hit  = 1'b1;
          gsel = idx;
        end
      end
    end
  end

  assign grant = rst && hit;

  // drive grant and the memory port in the same cycle as the decision
  always_comb begin
    bus.gnt       = '0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (grant) begin
      bus.gnt[gsel] = 1'b1;
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.we[gsel];
      bus.mem_addr  = bus.addr[int'(gsel)*AWIDTH +: AWIDTH];
      bus.mem_wdata = bus.wdata[int'(gsel)*DWIDTH +: DWIDTH];
    end
  end

  // next owner / burst count / read strobe; idle cycles leave state untouched
  always_comb begin
    owner_d  = owner_q;
    bcnt_d   = bcnt_q;
    fresh_d  = fresh_q;
    rvalid_d = '0;
    if (grant) begin
      owner_d = gsel;
      fresh_d = 1'b0;
      if (gsel == owner_q)
        bcnt_d = (fresh_q || (bcnt_q == BSAT)) ? BSAT : bcnt_q + 1'b1;
      else
        bcnt_d = '0;
      if (!bus.we[gsel])
        rvalid_d[gsel] = 1'b1;
    end
  end

  // state registers; reset drops any read strobe in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q  <= OWN_RST;
      bcnt_q   <= '0;
      fresh_q  <= 1'b1;
      rvalid_q <= '0;
    end else begin
      owner_q  <= owner_d;
      bcnt_q   <= bcnt_d;
      fresh_q  <= fresh_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign bus.rvalid = rvalid_q;
  // memory read data arrives one cycle after the read grant, aligned with rvalid
  assign bus.rdata  = rst ? bus.mem_rdata : '0;

  logic [NREQ-1:0][WW-1:0] wait_q;

  // consecutive cycles each requester has asked without being granted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_q <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++)
        wait_q[i] <= (bus.req[i] && !bus.gnt[i]) ? wait_q[i] + 1'b1 : '0;
    end
  end

  // protocol invariants, sampled at the clock while out of reset
  always @(posedge clk) begin
    if (rst) begin
      a_gnt_onehot: assert ($onehot0(bus.gnt));
      a_gnt_in_req: assert ((bus.gnt & ~bus.req) == '0);
      a_rv_onehot:  assert ($onehot0(bus.rvalid));
      for (int i = 0; i < NREQ; i++)
        assert (wait_q[i] < WW'(WAIT_MAX));
    end
  end
endmodule

// File: tb/tb_pkt_mem_arbiter.sv
// Randomized + directed bench for pkt_mem_arbiter. Two instances run side by
// side: A (2 requesters, burst 4) and B (3 requesters, burst 1). A behavioural
// model tracks the owner and its run length of consecutive grants, plus a
// shadow copy of each packet memory.
module tb_pkt_mem_arbiter;
  localparam int NA = 2, MBA = 4, NB = 3, MBB = 1, DW = 64, AW = 8;

  logic clk, rst;
  int   n_chk, n_pass;

  pkt_mem_arbiter_if #(.NREQ(NA), .DWIDTH(DW), .AWIDTH(AW)) bus_a ();
  pkt_mem_arbiter_if #(.NREQ(NB), .DWIDTH(DW), .AWIDTH(AW)) bus_b ();

  pkt_mem_arbiter #(.NREQ(NA), .DWIDTH(DW), .AWIDTH(AW), .MAX_BURST(MBA)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a));
  pkt_mem_arbiter #(.NREQ(NB), .DWIDTH(DW), .AWIDTH(AW), .MAX_BURST(MBB)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // per-dut, per-requester stimulus
  logic          rq  [2][4];
  logic          wen [2][4];
  logic [AW-1:0] ad  [2][4];
  logic [DW-1:0] wd  [2][4];

  always_comb begin
    bus_a.req = '0; bus_a.we = '0; bus_a.addr = '0; bus_a.wdata = '0;
    bus_b.req = '0; bus_b.we = '0; bus_b.addr = '0; bus_b.wdata = '0;
    for (int i = 0; i < NA; i++) begin
      bus_a.req[i] = rq[0][i];
      bus_a.we[i]  = wen[0][i];
      bus_a.addr[i*AW +: AW]  = ad[0][i];
      bus_a.wdata[i*DW +: DW] = wd[0][i];
    end
    for (int i = 0; i < NB; i++) begin
      bus_b.req[i] = rq[1][i];
      bus_b.we[i]  = wen[1][i];
      bus_b.addr[i*AW +: AW]  = ad[1][i];
      bus_b.wdata[i*DW +: DW] = wd[1][i];
    end
  end

  function automatic logic [DW-1:0] init_word(int d, int i);
    return 64'hA5A5_0000_0000_0000 | (64'(d) << 32) | 64'(i);
  endfunction

  // packet memories: synchronous single port, read data one cycle later
  logic [DW-1:0] mem_a [256];
  logic [DW-1:0] mem_b [256];
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 256; i++) begin
        mem_a[i] <= init_word(0, i);
        mem_b[i] <= init_word(1, i);
      end
      bus_a.mem_rdata <= '0;
      bus_b.mem_rdata <= '0;
    end else begin
      if (bus_a.mem_en) begin
        if (bus_a.mem_we) mem_a[bus_a.mem_addr] <= bus_a.mem_wdata;
        else              bus_a.mem_rdata       <= mem_a[bus_a.mem_addr];
      end
      if (bus_b.mem_en) begin
        if (bus_b.mem_we) mem_b[bus_b.mem_addr] <= bus_b.mem_wdata;
        else              bus_b.mem_rdata       <= mem_b[bus_b.mem_addr];
      end
    end
  end

  // reference model state
  int            own  [2];
  int            run  [2];   // consecutive grants held by own, capped at burst
  int            gexp [2];   // expected winner this cycle, -1 = none
  logic [3:0]    erv  [2];
  logic [DW-1:0] erd  [2];
  logic [DW-1:0] sh   [2][256];
  string         nm   [2] = '{"A", "B"};

  // observed outputs
  logic [3:0]    o_gnt [2];
  logic [3:0]    o_rv  [2];
  logic          o_en  [2];
  logic          o_we  [2];
  logic [AW-1:0] o_ad  [2];
  logic [DW-1:0] o_wd  [2];
  logic [DW-1:0] o_rd  [2];

  function automatic int nreq(int d);  return (d == 0) ? NA  : NB;  endfunction
  function automatic int mburst(int d); return (d == 0) ? MBA : MBB; endfunction

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
  endtask

  task automatic grab(int d);
    if (d == 0) begin
      o_gnt[d] = 4'(bus_a.gnt); o_rv[d] = 4'(bus_a.rvalid); o_en[d] = bus_a.mem_en;
      o_we[d] = bus_a.mem_we; o_ad[d] = bus_a.mem_addr; o_wd[d] = bus_a.mem_wdata;
      o_rd[d] = bus_a.rdata;
    end else begin
      o_gnt[d] = 4'(bus_b.gnt); o_rv[d] = 4'(bus_b.rvalid); o_en[d] = bus_b.mem_en;
      o_we[d] = bus_b.mem_we; o_ad[d] = bus_b.mem_addr; o_wd[d] = bus_b.mem_wdata;
      o_rd[d] = bus_b.rdata;
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      own[d]  = nreq(d) - 1;
      run[d]  = mburst(d);    // reset owner carries no burst credit
      erv[d]  = '0;
      erd[d]  = '0;
      gexp[d] = -1;
      for (int i = 0; i < 256; i++) sh[d][i] = init_word(d, i);
    end
  endtask

  // winner per the rules: owner keeps while run < burst or nobody else asks;
  // otherwise first requester found rotating upward from the owner
  function automatic int pick(int d);
    int  n;
    bit  others;
    n      = nreq(d);
    others = 1'b0;
    for (int i = 0; i < n; i++) if (rq[d][i] && i != own[d]) others = 1'b1;
    if (rq[d][own[d]] && (run[d] < mburst(d) || !others)) return own[d];
    for (int k = 1; k < n; k++) if (rq[d][(own[d] + k) % n]) return (own[d] + k) % n;
    return -1;
  endfunction

  task automatic commit(int d, int g);
    erv[d] = '0;
    if (g >= 0) begin
      if (g == own[d]) run[d] = (run[d] < mburst(d)) ? run[d] + 1 : run[d];
      else             run[d] = 1;
      own[d] = g;
      if (wen[d][g]) sh[d][ad[d][g]] = wd[d][g];
      else begin
        erv[d] = 4'(1) << g;
        erd[d] = sh[d][ad[d][g]];
      end
    end
  endtask

  task automatic check_cycle();
    for (int d = 0; d < 2; d++) begin
      grab(d);
      gexp[d] = pick(d);
      chk({nm[d], ".gnt"}, 64'(o_gnt[d]), (gexp[d] >= 0) ? (64'(1) << gexp[d]) : 64'(0));
      chk({nm[d], ".mem_en"}, 64'(o_en[d]), 64'(gexp[d] >= 0));
      if (gexp[d] >= 0) begin
        chk({nm[d], ".mem_we"},    64'(o_we[d]), 64'(wen[d][gexp[d]]));
        chk({nm[d], ".mem_addr"},  64'(o_ad[d]), 64'(ad[d][gexp[d]]));
        chk({nm[d], ".mem_wdata"}, o_wd[d],      wd[d][gexp[d]]);
      end
      chk({nm[d], ".rvalid"}, 64'(o_rv[d]), 64'(erv[d]));
      if (erv[d] != '0) chk({nm[d], ".rdata"}, o_rd[d], erd[d]);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    for (int d = 0; d < 2; d++) commit(d, gexp[d]);
    #1;
  endtask

  task automatic chk_quiet(string tag);
    for (int d = 0; d < 2; d++) begin
      grab(d);
      chk({tag, ".", nm[d], ".gnt"},    64'(o_gnt[d]), 64'(0));
      chk({tag, ".", nm[d], ".en"},     64'(o_en[d]),  64'(0));
      chk({tag, ".", nm[d], ".we"},     64'(o_we[d]),  64'(0));
      chk({tag, ".", nm[d], ".addr"},   64'(o_ad[d]),  64'(0));
      chk({tag, ".", nm[d], ".wdata"},  o_wd[d],       64'(0));
      chk({tag, ".", nm[d], ".rvalid"}, 64'(o_rv[d]),  64'(0));
      chk({tag, ".", nm[d], ".rdata"},  o_rd[d],       64'(0));
    end
  endtask

  task automatic clear_inputs();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 4; i++) begin
        rq[d][i] = 1'b0; wen[d][i] = 1'b0; ad[d][i] = '0; wd[d][i] = '0;
      end
  endtask

  // reset pulse; outputs must stay quiet even with every request raised
  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < nreq(d); i++) begin
        rq[d][i] = 1'b1; wen[d][i] = 1'b1; ad[d][i] = 8'h3; wd[d][i] = '1;
      end
    #1 chk_quiet("rst");
    clear_inputs();
    rst = 1'b1;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    clear_inputs();
    rst = 1'b0;
    model_reset();

    // 1: two readers held on A -> 4 grants each, rvalid trails by one cycle
    do_reset();
    for (int i = 0; i < 2; i++) begin rq[0][i] = 1'b1; ad[0][i] = 8'(i + 1); end
    for (int c = 0; c < 9; c++) begin
      cyc();
      chk("burst.gnt", 64'(o_gnt[0]), (c < 4 || c >= 8) ? 64'd1 : 64'd2);
      if (c > 0) chk("burst.rv", 64'(o_rv[0]), (c - 1 < 4) ? 64'd1 : 64'd2);
    end

    // 2: sole requester 1 keeps the grant; a newcomer takes over once saturated
    do_reset();
    rq[0][1] = 1'b1; ad[0][1] = 8'h05;
    for (int c = 0; c < 6; c++) begin
      cyc();
      chk("solo.gnt", 64'(o_gnt[0]), 64'd2);
    end
    rq[0][0] = 1'b1;
    cyc();
    chk("solo.join", 64'(o_gnt[0]), 64'd1);

    // 3: write then read of the same address returns the new data
    do_reset();
    rq[0][0] = 1'b1; wen[0][0] = 1'b1; ad[0][0] = 8'h10; wd[0][0] = 64'hDEADBEEF_00000001;
    cyc();
    chk("raw.wr", 64'(o_gnt[0]), 64'd1);
    rq[0][0] = 1'b0; rq[0][1] = 1'b1; wen[0][1] = 1'b0; ad[0][1] = 8'h10;
    cyc();
    chk("raw.rdg", 64'(o_gnt[0]), 64'd2);
    rq[0][1] = 1'b0;
    cyc();
    chk("raw.rv", 64'(o_rv[0]), 64'd2);
    chk("raw.rdata", o_rd[0], 64'hDEADBEEF_00000001);

    // 4: burst of one on B -> strict rotation among three
    do_reset();
    for (int i = 0; i < 3; i++) begin rq[1][i] = 1'b1; ad[1][i] = 8'(i); end
    for (int c = 0; c < 6; c++) begin
      cyc();
      chk("rr3.gnt", 64'(o_gnt[1]), 64'(1) << (c % 3));
    end

    // 5: reset lands between a read grant and its strobe
    do_reset();
    rq[0][0] = 1'b1; ad[0][0] = 8'h7;
    @(negedge clk);
    check_cycle();
    chk("mid.gnt", 64'(o_gnt[0]), 64'd1);
    #2 rst = 1'b0;
    model_reset();
    #1 chk_quiet("mid");
    @(posedge clk);
    #1 grab(0);
    chk("mid.rv", 64'(o_rv[0]), 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    rq[0][1] = 1'b1;
    cyc();
    chk("mid.first", 64'(o_gnt[0]), 64'd1);

    // 6: idle gap keeps owner and burst progress
    do_reset();
    rq[0][0] = 1'b1;
    cyc(); chk("gap.g0", 64'(o_gnt[0]), 64'd1);
    cyc(); chk("gap.g1", 64'(o_gnt[0]), 64'd1);
    rq[0][0] = 1'b0;
    cyc(); chk("gap.idle", 64'(o_gnt[0]), 64'd0);
    chk("gap.en", 64'(o_en[0]), 64'd0);
    rq[0][0] = 1'b1; rq[0][1] = 1'b1;
    cyc(); chk("gap.g3", 64'(o_gnt[0]), 64'd1);
    cyc(); chk("gap.g4", 64'(o_gnt[0]), 64'd1);
    cyc(); chk("gap.g5", 64'(o_gnt[0]), 64'd2);

    // random traffic on both instances; pending requests are held until granted
    for (int c = 0; c < 500; c++) begin
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < nreq(d); i++) begin
          if (rq[d][i] && gexp[d] != i) continue;
          if (rq[d][i]) rq[d][i] = ($urandom_range(0, 3) != 0);
          else          rq[d][i] = ($urandom_range(0, 2) == 0);
          wen[d][i] = ($urandom_range(0, 2) == 0);
          ad[d][i]  = 8'($urandom_range(0, 15));
          wd[d][i]  = {$urandom, $urandom};
        end
      end
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
